// File: rtl/alu_pkg.sv
// Shared types for the ALU command queue: opcodes, the queued command word,
// and the captured ALU flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    NOT = 3'd5,
    SHL = 3'd6,
    SHR = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    alu_op_e    op;
  } alu_cmd_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of ALU commands; head is read combinationally and forced
// to zero when the FIFO is empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  alu_cmd_t               push_data_i,
  input  logic                   pop_i,
  output alu_cmd_t               head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]     CNT_FULL = (AW + 1)'(DEPTH);

  alu_cmd_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  // NOTE: every signal gets its default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately left unreset; count gates every read, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/alu_issue_queue.sv
// Command FIFO in front of an external combinational ALU, with a registered
// valid/ready result slot and sticky carry/overflow status.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_a,
  input  logic [7:0]             in_b,
  input  logic [2:0]             in_op,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [2:0]             alu_op,
  input  logic [7:0]             alu_result,
  input  logic                   alu_carry,
  input  logic                   alu_zero,
  input  logic                   alu_overflow,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_result,
  output logic [2:0]             out_op,
  output logic                   out_carry,
  output logic                   out_zero,
  output logic                   out_overflow,
  output logic                   sticky_carry,
  output logic                   sticky_ovf,
  input  logic                   sticky_clr,
  output logic [$clog2(DEPTH):0] fifo_count
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  alu_cmd_t    in_cmd, head;
  alu_flags_t  alu_flags;
  logic        fifo_full, fifo_empty, push, capture;

  slot_state_e slot_q, slot_d;
  logic [7:0]  result_q, result_d;
  alu_op_e     op_q, op_d;
  alu_flags_t  flags_q, flags_d;
  logic        sticky_carry_q, sticky_carry_d;
  logic        sticky_ovf_q, sticky_ovf_d;

  assign in_cmd    = '{a: in_a, b: in_b, op: alu_op_e'(in_op)};
  assign alu_flags = '{carry: alu_carry, zero: alu_zero, overflow: alu_overflow};

  // in_ready looks only at occupancy, so nothing here depends on in_valid.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign capture  = !fifo_empty && (slot_q == SLOT_EMPTY || out_ready);

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (in_cmd),
    .pop_i       (capture),
    .head_o      (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign alu_a  = head.a;
  assign alu_b  = head.b;
  assign alu_op = head.op;

  always_comb begin
    slot_d = slot_q;
    unique case (slot_q)
      SLOT_EMPTY: if (capture) slot_d = SLOT_FULL;
      SLOT_FULL:  if (!capture && out_ready) slot_d = SLOT_EMPTY;
      default:    slot_d = SLOT_EMPTY;
    endcase
  end

  // Slot data only moves on capture, which holds it stable under backpressure.
  always_comb begin
    result_d       = result_q;
    op_d           = op_q;
    flags_d        = flags_q;
    if (capture) begin
      result_d = alu_result;
      op_d     = head.op;
      flags_d  = alu_flags;
    end
    sticky_carry_d = (sticky_clr ? 1'b0 : sticky_carry_q) | (capture & alu_carry);
    sticky_ovf_d   = (sticky_clr ? 1'b0 : sticky_ovf_q)   | (capture & alu_overflow);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q         <= SLOT_EMPTY;
      result_q       <= '0;
      op_q           <= ADD;
      flags_q        <= '0;
      sticky_carry_q <= 1'b0;
      sticky_ovf_q   <= 1'b0;
    end else begin
      slot_q         <= slot_d;
      result_q       <= result_d;
      op_q           <= op_d;
      flags_q        <= flags_d;
      sticky_carry_q <= sticky_carry_d;
      sticky_ovf_q   <= sticky_ovf_d;
    end
  end

  assign out_valid    = (slot_q == SLOT_FULL);
  assign out_result   = result_q;
  assign out_op       = op_q;
  assign out_carry    = flags_q.carry;
  assign out_zero     = flags_q.zero;
  assign out_overflow = flags_q.overflow;
  assign sticky_carry = sticky_carry_q;
  assign sticky_ovf   = sticky_ovf_q;

endmodule
